softmax_unit: RTL
=================

Name: softmax_unit

Overview:
- Row-wise softmax stage between the QK score stage and the attention-weighting stage.
- Started by the controller's softmax_start pulse.
- Reads the SEQ_LEN x SEQ_LEN score matrix from the score buffer and writes the normalised probability matrix to the probability buffer.
- Pulses done when the last row has been written.

Parameters:
- SEQ_LEN, 8, rows and columns of the score matrix; power of two, minimum 2.
- SCORE_W, 16, signed Q8.8 score width.
- PROB_W, 16, unsigned Q1.15 probability and exp width; 1.0 = 0x8000.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle start pulse
- busy  out  1  high from the cycle after start is accepted until done
- done  out  1  one-cycle pulse on completion
- score_rd_en  out  1  score buffer read strobe
- score_addr  out  2*clog2(SEQ_LEN)  address = {row, col}
- score_rdata  in  SCORE_W  read data, valid exactly 1 cycle after score_rd_en
- prob_we  out  1  probability buffer write strobe
- prob_addr  out  2*clog2(SEQ_LEN)  address = {row, col}
- prob_wdata  out  PROB_W  Q1.15 probability

Behaviour:
- Reset: rst_n low clears everything immediately, mid-operation included. State goes to IDLE; busy, done, score_rd_en and prob_we go to 0; addresses and wdata go to 0; partial results are discarded.
- States: IDLE, MAX, EXP, NORM, DONE.
- IDLE:
  - start=1 moves to MAX with row=0.
  - start while not IDLE is ignored.
- MAX:
  - Issues reads col 0..SEQ_LEN-1 on consecutive cycles, then one drain cycle (SEQ_LEN+1 cycles).
  - Tracks the signed row maximum; the first returned element initialises it.
- EXP:
  - Re-reads the row over SEQ_LEN+1 cycles.
  - diff = max - score, unsigned, SCORE_W+1 bits.
  - LUT index = diff[11:4], saturated to 255 when diff >= 16.0.
  - e = EXP_LUT[idx] = round(exp(-idx/16)*32768).
  - Each e is stored in a local SEQ_LEN-entry buffer and added to sum, which is PROB_W+clog2(SEQ_LEN) bits wide and cannot overflow.
- NORM: for each col:
  - Cycle 1: launch divider with (e << 15) / sum.
  - Cycles 2-17: PROB_W divide iterations.
  - Cycle 18: prob_we=1, prob_wdata = floor quotient, saturated to 0x8000.
  - That is 18 cycles per element.
  - After col SEQ_LEN-1: if row < SEQ_LEN-1, increment row and go to MAX; otherwise go to DONE.
- DONE: done=1 for one cycle, busy drops the same cycle, return to IDLE.
- Row latency: 2(SEQ_LEN+1) + 18*SEQ_LEN cycles; 162 for SEQ_LEN=8.
- done pulses SEQ_LEN*rowlatency + 1 cycles after start is sampled: 1297 for defaults.
- sum is never 0, because the maximum element always contributes 0x8000.
- Outputs are registered.
- Reads and writes never overlap. Each address is written exactly once per run.

Optional Feature:
- Macro SOFTMAX_CAUSAL_MASK_EN.
- When defined:
  - Columns with col > row are excluded from the max.
  - Their e is forced to 0 and their prob_wdata is 0.
  - Timing is unchanged; the reads still occur.
- Undefined: full unmasked softmax.

Decomposition:
- Package softmax_pkg holds:
  - the state typedef;
  - the EXP_LUT constant array (256 x PROB_W);
  - the LUT step and saturation constants;
  - the ONE_Q15 = 0x8000 constant.
- One sub-module: softmax_div, a sequential restoring divider.
  - Interface: start / dividend / divisor in, busy / valid / quotient out, one bit per cycle.
  - Latency: PROB_W cycles after the launch cycle.

Test Plan:
- All scores 0 → every prob_wdata = 0x1000 (4096); 64 writes; done 1297 cycles after start.
- Row 0 = {0x0400, 0,0,0,0,0,0,0}, other rows 0:
  - LUT[64]=600, sum=36968.
  - prob[0][0]=29045; prob[0][1..7]=531 each.
  - Other rows 0x1000.
- Row with one element 0x1800 (24.0), rest 0 → diff saturates to index 255 (LUT=0); big element 0x8000, others 0.
- Assert rst_n low during NORM of row 3 → all outputs 0 next edge, no further writes; a new start rerun produces full correct results.
- start pulsed again while busy, plus a second pulse in the same cycle as done → both ignored; exactly one done pulse, busy low afterwards.
- SOFTMAX_CAUSAL_MASK_EN defined, all scores 0 → row r has prob = floor(32768/(r+1)) for col ≤ r and 0 above; row 0 col 0 = 0x8000.

Source files
------------

// File: rtl/softmax_pkg.sv
// rtl/softmax_pkg.sv - shared types, exp lookup table and fixed-point constants for softmax_unit
package softmax_pkg;

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        MAX  = 3'd1,
        EXP  = 3'd2,
        NORM = 3'd3,
        DONE = 3'd4
    } state_t;

    localparam int LUT_W       = 16;
    localparam int LUT_IDX_W   = 8;
    localparam int LUT_DEPTH   = 1 << LUT_IDX_W;
    localparam int SCORE_FRAC  = 8;
    // Each LUT step is 1/16 of a score unit, so the index is diff >> 4.
    localparam int LUT_SHIFT   = 4;
    localparam int LUT_SAT_IDX = LUT_DEPTH - 1;
    localparam int LUT_SAT_DIFF = 1 << (LUT_SHIFT + LUT_IDX_W);
    localparam logic [LUT_W-1:0] ONE_Q15 = 16'h8000;

    // exp(-1/16) in Q32; the table is built by repeated multiplication in Q32.
    localparam logic [63:0] EXP_STEP_Q32 = 64'd4034748382;

    function automatic logic [LUT_DEPTH-1:0][LUT_W-1:0] build_exp_lut();
        logic [LUT_DEPTH-1:0][LUT_W-1:0] lut;
        logic [63:0] acc;
        acc = 64'd1 << 47;
        for (int i = 0; i < LUT_DEPTH; i++) begin
            lut[i] = LUT_W'((acc + 64'h8000_0000) >> 32);
            acc    = 64'(({64'd0, acc} * {64'd0, EXP_STEP_Q32}) >> 32);
        end
        return lut;
    endfunction

    // EXP_LUT[i] = round(exp(-i/16) * 32768)
    localparam logic [LUT_DEPTH-1:0][LUT_W-1:0] EXP_LUT = build_exp_lut();

endpackage

// File: rtl/softmax_div.sv
// rtl/softmax_div.sv - sequential restoring divider, one quotient bit per cycle
module softmax_div #(
    parameter int Q_W   = 16,
    parameter int DD_W  = 31,
    parameter int DVS_W = 19
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [DD_W-1:0]  dividend,
    input  logic [DVS_W-1:0] divisor,
    output logic             busy,
    output logic             valid,
    output logic [Q_W-1:0]   quotient
);
    localparam int CNT_W = $clog2(Q_W + 1);

    logic [DVS_W-1:0] rem;
    logic [DVS_W-1:0] rem_src;
    logic [DVS_W-1:0] rem_nxt;
    logic [DVS_W-1:0] dvs_q;
    logic [DVS_W-1:0] dvs;
    logic [Q_W-1:0]   q_src;
    logic [DVS_W:0]   trial;
    logic             ge;
    logic [CNT_W-1:0] cnt;

    // The launch cycle performs the first iteration straight from the inputs;
    // callers guarantee dividend >> Q_W < divisor so the quotient fits Q_W bits.
    always_comb begin
        rem_src = start ? DVS_W'(dividend >> Q_W) : rem;
        q_src   = start ? dividend[Q_W-1:0] : quotient;
        dvs     = start ? divisor : dvs_q;
        trial   = {rem_src, q_src[Q_W-1]};
        ge      = (trial >= {1'b0, dvs});
        rem_nxt = ge ? DVS_W'(trial - {1'b0, dvs}) : trial[DVS_W-1:0];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rem      <= '0;
            dvs_q    <= '0;
            quotient <= '0;
            cnt      <= '0;
            busy     <= 1'b0;
            valid    <= 1'b0;
        end else begin
            valid <= 1'b0;
            if (start) begin
                rem      <= rem_nxt;
                quotient <= {q_src[Q_W-2:0], ge};
                dvs_q    <= divisor;
                cnt      <= CNT_W'(Q_W - 1);
                busy     <= 1'b1;
            end else if (busy) begin
                rem      <= rem_nxt;
                quotient <= {q_src[Q_W-2:0], ge};
                cnt      <= cnt - CNT_W'(1);
                if (cnt == CNT_W'(1)) begin
                    busy  <= 1'b0;
                    valid <= 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/softmax_unit.sv
// rtl/softmax_unit.sv - row-wise softmax over the score matrix; SOFTMAX_CAUSAL_MASK_EN enables causal masking
module softmax_unit
    import softmax_pkg::*;
#(
    parameter int SEQ_LEN = 8,
    parameter int SCORE_W = 16,
    parameter int PROB_W  = 16
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           start,
    output logic                           busy,
    output logic                           done,
    output logic                           score_rd_en,
    output logic [2*$clog2(SEQ_LEN)-1:0]   score_addr,
    input  logic [SCORE_W-1:0]             score_rdata,
    output logic                           prob_we,
    output logic [2*$clog2(SEQ_LEN)-1:0]   prob_addr,
    output logic [PROB_W-1:0]              prob_wdata
);
    localparam int IDX_W = $clog2(SEQ_LEN);
    localparam int PH_W  = IDX_W + 1;
    localparam int SUM_W = PROB_W + IDX_W;
    localparam int DD_W  = 2 * PROB_W - 1;
    localparam int K_W   = $clog2(PROB_W + 2);
    localparam logic [PH_W-1:0]  PH_ONE   = PH_W'(1);
    localparam logic [PH_W-1:0]  PH_LAST  = PH_W'(SEQ_LEN);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(SEQ_LEN - 1);
    localparam logic [K_W-1:0]   K_WRITE  = K_W'(PROB_W);
    localparam logic [K_W-1:0]   K_LAST   = K_W'(PROB_W + 1);
    localparam logic [SCORE_W:0] DIFF_SAT = (SCORE_W+1)'(LUT_SAT_DIFF);
    localparam logic [PROB_W-1:0] ONE_P   = PROB_W'(ONE_Q15);

    state_t             state, state_n;
    logic [IDX_W-1:0]   row, row_n;
    logic [PH_W-1:0]    phase, phase_n;
    logic [IDX_W-1:0]   col, col_n;
    logic [K_W-1:0]     k, k_n;

    logic signed [SCORE_W-1:0] max_val;
    logic [SUM_W-1:0]   sum;
    logic [PROB_W-1:0]  ebuf [SEQ_LEN];

    logic [IDX_W-1:0]   rd_col;
    logic               col_keep;
    logic [SCORE_W:0]   diff;
    logic [LUT_IDX_W-1:0] lut_idx;
    logic [PROB_W-1:0]  e_val;
    logic               rd_n;
    logic               wr_n;
    logic [PROB_W-1:0]  prob_sat;

    logic               div_start;
    logic               div_busy;
    logic               div_valid;
    logic [PROB_W-1:0]  div_q;

    // Data returned in phase p belongs to the read issued in phase p-1.
    assign rd_col = IDX_W'(phase - PH_ONE);

`ifdef SOFTMAX_CAUSAL_MASK_EN
    assign col_keep = (rd_col <= row);
`else
    assign col_keep = 1'b1;
`endif

    assign diff    = {max_val[SCORE_W-1], max_val} - {score_rdata[SCORE_W-1], score_rdata};
    assign lut_idx = (diff >= DIFF_SAT) ? LUT_IDX_W'(LUT_SAT_IDX) : LUT_IDX_W'(diff >> LUT_SHIFT);
    assign e_val   = col_keep ? PROB_W'(EXP_LUT[lut_idx]) : '0;

    assign div_start = (state == NORM) && (k == '0) && !div_busy;
    assign wr_n      = (state == NORM) && (k == K_WRITE) && div_valid;
    assign prob_sat  = (div_q > ONE_P) ? ONE_P : div_q;

    softmax_div #(
        .Q_W   (PROB_W),
        .DD_W  (DD_W),
        .DVS_W (SUM_W)
    ) u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (div_start),
        .dividend ({ebuf[col], {(PROB_W-1){1'b0}}}),
        .divisor  (sum),
        .busy     (div_busy),
        .valid    (div_valid),
        .quotient (div_q)
    );

    always_comb begin
        state_n = state;
        row_n   = row;
        phase_n = phase;
        col_n   = col;
        k_n     = k;
        case (state)
            IDLE: begin
                if (start) begin
                    state_n = MAX;
                    row_n   = '0;
                    phase_n = '0;
                end
            end
            MAX: begin
                if (phase == PH_LAST) begin
                    state_n = EXP;
                    phase_n = '0;
                end else begin
                    phase_n = phase + PH_ONE;
                end
            end
            EXP: begin
                if (phase == PH_LAST) begin
                    state_n = NORM;
                    col_n   = '0;
                    k_n     = '0;
                end else begin
                    phase_n = phase + PH_ONE;
                end
            end
            NORM: begin
                if (k == K_LAST) begin
                    k_n = '0;
                    if (col == IDX_LAST) begin
                        if (row == IDX_LAST) begin
                            state_n = DONE;
                        end else begin
                            state_n = MAX;
                            row_n   = row + IDX_W'(1);
                            phase_n = '0;
                        end
                    end else begin
                        col_n = col + IDX_W'(1);
                    end
                end else begin
                    k_n = k + K_W'(1);
                end
            end
            DONE:    state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    assign rd_n = ((state_n == MAX) || (state_n == EXP)) && (phase_n < PH_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            row         <= '0;
            phase       <= '0;
            col         <= '0;
            k           <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            score_rd_en <= 1'b0;
            score_addr  <= '0;
            prob_we     <= 1'b0;
            prob_addr   <= '0;
            prob_wdata  <= '0;
        end else begin
            state       <= state_n;
            row         <= row_n;
            phase       <= phase_n;
            col         <= col_n;
            k           <= k_n;
            busy        <= (state_n == MAX) || (state_n == EXP) || (state_n == NORM);
            done        <= (state_n == DONE);
            score_rd_en <= rd_n;
            score_addr  <= rd_n ? {row_n, phase_n[IDX_W-1:0]} : '0;
            prob_we     <= wr_n;
            prob_addr   <= wr_n ? {row, col} : '0;
            prob_wdata  <= wr_n ? prob_sat : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            max_val <= '0;
            sum     <= '0;
            for (int i = 0; i < SEQ_LEN; i++) begin
                ebuf[i] <= '0;
            end
        end else begin
            if ((state == MAX) && (phase != '0)) begin
                if (phase == PH_ONE) begin
                    max_val <= $signed(score_rdata);
                end else if (col_keep && ($signed(score_rdata) > max_val)) begin
                    max_val <= $signed(score_rdata);
                end
            end
            if ((state == EXP) && (phase != '0)) begin
                ebuf[rd_col] <= e_val;
                sum <= (phase == PH_ONE) ? SUM_W'(e_val) : sum + SUM_W'(e_val);
            end
        end
    end

endmodule
